// File: rtl/serial_prime_sieve.sv
// serial_prime_sieve
// Accepts a WIDTH-bit unsigned number MSB-first, one bit per accepted cycle,
// and keeps one residue per divisor channel. At the end of the frame it
// publishes the reassembled value, a divisibility flag per channel and a
// primality verdict derived from those flags.
//
// Handshake: a bit is consumed on a rising edge iff the FSM is in SHIFT and
// bit_valid is 1; there is no back-pressure (busy only reports that a frame
// is open). start is honoured only in IDLE or DONE, and bit_valid in that
// same cycle is ignored. done is a single-cycle pulse marking fresh results.
module serial_prime_sieve #(
  parameter int WIDTH = 8,
  parameter int NUM_DIV = 6,
  parameter logic [8*NUM_DIV-1:0] DIV_LIST = {8'd13, 8'd11, 8'd7, 8'd5, 8'd3, 8'd2}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   value_out,
  output logic [NUM_DIV-1:0] div_flags,
  output logic               is_prime
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_next;
  logic [CW-1:0]      cnt;
  logic               last_bit;
  logic [7:0]         res      [NUM_DIV];
  logic [7:0]         res_next [NUM_DIV];
  logic [8:0]         tsum     [NUM_DIV];
  logic [8:0]         div9     [NUM_DIV];
  logic [NUM_DIV-1:0] flags_next;
  logic               prime_next;
  logic [31:0]        val32;

  // Next shift register, residues, flags and verdict as if bit_in is accepted now.
  always_comb begin
    shreg_next = {shreg[WIDTH-2:0], bit_in};
    val32      = 32'(shreg_next);
    last_bit   = (cnt == CW'(WIDTH - 1));
    flags_next = '0;
    prime_next = (val32 >= 32'd2);
    for (int i = 0; i < NUM_DIV; i++) begin
      div9[i]     = {1'b0, DIV_LIST[8*i +: 8]};
      // Residue stays below the divisor, so 2r+b < 2D and one subtract is enough.
      tsum[i]     = {res[i], bit_in};
      res_next[i] = tsum[i][7:0];
      if (tsum[i] >= div9[i]) begin
        res_next[i] = 8'(tsum[i] - div9[i]);
      end
      flags_next[i] = (res_next[i] == 8'd0);
      // A divisor flag only disqualifies the value when the value is not that divisor itself.
      if (flags_next[i] && (val32 != {24'd0, DIV_LIST[8*i +: 8]})) begin
        prime_next = 1'b0;
      end
    end
  end

  // Frame FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      value_out <= '0;
      div_flags <= '0;
      is_prime  <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      for (int i = 0; i < NUM_DIV; i++) res[i] <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            shreg <= '0;
            cnt   <= '0;
            for (int i = 0; i < NUM_DIV; i++) res[i] <= 8'd0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            shreg <= shreg_next;
            for (int i = 0; i < NUM_DIV; i++) res[i] <= res_next[i];
            if (last_bit) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cnt       <= '0;
              value_out <= shreg_next;
              div_flags <= flags_next;
              is_prime  <= prime_next;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_prime_sieve.sv
// tb_serial_prime_sieve
// Directed frames with hand-computed results for the default divisor set
// {13,11,7,5,3,2}; channel 0 is divisor 2, channel 5 is divisor 13.
module tb_serial_prime_sieve;

  logic       clk;
  logic       reset;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic       busy;
  logic       done;
  logic [7:0] value_out;
  logic [5:0] div_flags;
  logic       is_prime;

  int n_vec;
  int n_err;

  serial_prime_sieve dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .value_out (value_out),
    .div_flags (div_flags),
    .is_prime  (is_prime)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with noise on the data lines; start held low.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      bit_valid = 1'(($urandom_range(0, 1)));
      bit_in    = 1'(($urandom_range(0, 1)));
      step();
    end
    bit_valid = 1'b0;
  endtask

  // Driver: start cycle is cycle 0, then MSB-first bits with optional mid-frame stalls
  // and optional start pokes while shifting. Returns the cycle at which done was seen
  // (or the bound) and whether busy was high and done low on every shifting cycle.
  task automatic send_frame(input logic [7:0] v, input int nstall, input bit poke_start,
                            output int lat, output bit busy_ok);
    int k;
    int stall_left;
    int cycle;
    busy_ok    = 1'b1;
    stall_left = nstall;
    start      = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = ~v[7];
    step();
    cycle = 1;
    k     = 7;
    while (k >= 0 && cycle < 40) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      start = poke_start ? 1'(($urandom_range(0, 1))) : 1'b0;
      if (stall_left > 0 && k < 7 && k > 0 && (($urandom_range(0, 1) == 1) || k <= stall_left)) begin
        bit_valid  = 1'b0;
        bit_in     = 1'(($urandom_range(0, 1)));
        stall_left = stall_left - 1;
      end else begin
        bit_valid = 1'b1;
        bit_in    = v[k];
        k         = k - 1;
      end
      step();
      cycle = cycle + 1;
    end
    start     = 1'b0;
    bit_valid = 1'b0;
    lat       = cycle;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (3) step();
    n_vec++;
    if ({busy, done, value_out, div_flags, is_prime} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b value=%h flags=%b prime=%b, want all 0",
               busy, done, value_out, div_flags, is_prime);
    end
    reset = 1'b1;
    idle(2);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  // Contiguous frames: value, expected flags, expected verdict, latency 9.
  task automatic test_contiguous();
    logic [7:0] vals  [7] = '{8'd251, 8'd221, 8'd13, 8'd6, 8'd0, 8'd1, 8'd77};
    logic [5:0] flags [7] = '{6'b000000, 6'b100000, 6'b100000, 6'b000011,
                              6'b111111, 6'b000000, 6'b011000};
    logic       prime [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    bit bok;
    for (int i = 0; i < 7; i++) begin
      idle(1);
      send_frame(vals[i], 0, 1'b0, lat, bok);
      n_vec++;
      if (lat !== 9 || done !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL contig_latency v=%0d: got done at cycle %0d done=%b busy=%b, want cycle 9 done=1 busy=0",
                 vals[i], lat, done, busy);
      end
      n_vec++;
      if (!bok) begin
        n_err++;
        $display("FAIL contig_busy v=%0d: busy/done wrong during shift, want busy=1 done=0 cycles 1..8", vals[i]);
      end
      n_vec++;
      if (value_out !== vals[i] || div_flags !== flags[i] || is_prime !== prime[i]) begin
        n_err++;
        $display("FAIL contig_result v=%0d: got value=%0d flags=%b prime=%b, want value=%0d flags=%b prime=%b",
                 vals[i], value_out, div_flags, is_prime, vals[i], flags[i], prime[i]);
      end
    end
  endtask

  // 255 = 3*5*17, then results must hold through idle cycles with noisy inputs.
  task automatic test_hold();
    int lat;
    bit bok;
    idle(1);
    send_frame(8'd255, 0, 1'b0, lat, bok);
    idle(4);
    n_vec++;
    if (value_out !== 8'd255 || div_flags !== 6'b000110 || is_prime !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL hold: got value=%0d flags=%b prime=%b done=%b, want value=255 flags=000110 prime=0 done=0",
               value_out, div_flags, is_prime, done);
    end
  endtask

  // 251 with three stall cycles and start poked during SHIFT -> done at cycle 12.
  task automatic test_stall_and_start();
    int lat;
    bit bok;
    idle(1);
    send_frame(8'd251, 3, 1'b1, lat, bok);
    n_vec++;
    if (lat !== 12 || done !== 1'b1) begin
      n_err++;
      $display("FAIL stall_latency: got done at cycle %0d done=%b, want cycle 12 done=1", lat, done);
    end
    n_vec++;
    if (!bok) begin
      n_err++;
      $display("FAIL stall_busy: busy/done wrong during shift, want busy=1 done=0 cycles 1..11");
    end
    n_vec++;
    if (value_out !== 8'hFB || div_flags !== 6'b000000 || is_prime !== 1'b1) begin
      n_err++;
      $display("FAIL stall_result: got value=%h flags=%b prime=%b, want value=fb flags=000000 prime=1",
               value_out, div_flags, is_prime);
    end
  endtask

  // Reset after 4 bits discards the frame; then frame 2; then a back-to-back frame 77.
  task automatic test_reset_midframe_and_back_to_back();
    logic [7:0] pat;
    int lat;
    bit bok;
    pat = 8'b1011_0110;
    idle(1);
    start     = 1'b1;
    bit_valid = 1'b0;
    step();
    start = 1'b0;
    for (int k = 7; k > 3; k--) begin
      bit_valid = 1'b1;
      bit_in    = pat[k];
      step();
    end
    bit_valid = 1'b0;
    reset     = 1'b0;
    step();
    n_vec++;
    if ({busy, done, value_out, div_flags, is_prime} !== 17'd0) begin
      n_err++;
      $display("FAIL midframe_reset: got busy=%b done=%b value=%h flags=%b prime=%b, want all 0",
               busy, done, value_out, div_flags, is_prime);
    end
    reset = 1'b1;
    idle(2);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL after_midframe_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
    send_frame(8'd2, 0, 1'b0, lat, bok);
    n_vec++;
    if (lat !== 9 || value_out !== 8'd2 || div_flags !== 6'b000001 || is_prime !== 1'b1) begin
      n_err++;
      $display("FAIL frame_two: got cycle=%0d value=%0d flags=%b prime=%b, want cycle=9 value=2 flags=000001 prime=1",
               lat, value_out, div_flags, is_prime);
    end
    // Still in the DONE cycle: start now must open the next frame with no IDLE gap.
    send_frame(8'd77, 0, 1'b0, lat, bok);
    n_vec++;
    if (lat !== 9 || !bok) begin
      n_err++;
      $display("FAIL back_to_back_timing: got cycle=%0d busy_ok=%0d, want cycle=9 busy_ok=1", lat, bok);
    end
    n_vec++;
    if (value_out !== 8'd77 || div_flags !== 6'b011000 || is_prime !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back_result: got value=%0d flags=%b prime=%b, want value=77 flags=011000 prime=0",
               value_out, div_flags, is_prime);
    end
    step();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_width: got done=%b busy=%b one cycle later, want 0 0", done, busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_contiguous();
    test_hold();
    test_stall_and_start();
    test_reset_midframe_and_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
